// File: rtl/fwd_hazard_ctrl.sv
// Operand-forwarding select generator and load-use stall detector for the EX-stage operand muxes.
// Optional stall statistics counter enabled by defining FWD_STATS_EN.
module fwd_hazard_ctrl #(
  parameter int unsigned REG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_wr_en,
  input  logic             id_is_load,
  input  logic             flush,
  input  logic             freeze,
  output logic [1:0]       sel_a,
  output logic [1:0]       sel_b,
  output logic             stall,
  output logic [31:0]      stall_count
);

  localparam int unsigned CNT_W = 32;

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b01;
  localparam logic [1:0] SEL_WB  = 2'b10;
  localparam logic [1:0] SEL_WBL = 2'b11;

  // The load flag only matters while the producer is in EX, so it is kept beside the EX entry.
  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             wr;
  } stage_t;

  stage_t ex_q, ex_d, mem_q, mem_d, wb_q, wb_d, wbl_q, wbl_d;
  logic   ex_load_q, ex_load_d;
  logic [1:0] sel_a_q, sel_a_d, sel_b_q, sel_b_d;

  logic ex_prod, mem_prod, wb_prod, wbl_prod;
  logic hit_rs1, hit_rs2, load_use;
  logic [1:0] code_a, code_b;

  function automatic logic [1:0] fwd_code(
    input logic             used,
    input logic [REG_W-1:0] src,
    input logic             exp,
    input logic [REG_W-1:0] ex_rd,
    input logic             memp,
    input logic [REG_W-1:0] mem_rd,
    input logic             wbp,
    input logic [REG_W-1:0] wb_rd,
    input logic             wblp,
    input logic [REG_W-1:0] wbl_rd
  );
    logic [1:0] code;
    code = SEL_RF;
    if (used && (src != '0)) begin
      if (exp && (ex_rd == src))        code = SEL_MEM;
      else if (memp && (mem_rd == src)) code = SEL_WB;
      else if (wbp && (wb_rd == src))   code = SEL_WBL;
      // WBL producer has already written the regfile (read-after-write)
      else if (wblp && (wbl_rd == src)) code = SEL_RF;
    end
    return code;
  endfunction

  always_comb begin
    ex_prod  = ex_q.valid  & ex_q.wr  & (ex_q.rd  != '0);
    mem_prod = mem_q.valid & mem_q.wr & (mem_q.rd != '0);
    wb_prod  = wb_q.valid  & wb_q.wr  & (wb_q.rd  != '0);
    wbl_prod = wbl_q.valid & wbl_q.wr & (wbl_q.rd != '0);

    code_a = fwd_code(id_use_rs1, id_rs1, ex_prod, ex_q.rd, mem_prod, mem_q.rd,
                      wb_prod, wb_q.rd, wbl_prod, wbl_q.rd);
    code_b = fwd_code(id_use_rs2, id_rs2, ex_prod, ex_q.rd, mem_prod, mem_q.rd,
                      wb_prod, wb_q.rd, wbl_prod, wbl_q.rd);

    hit_rs1  = id_use_rs1 & (id_rs1 != '0) & ex_prod & ex_load_q & (ex_q.rd == id_rs1);
    hit_rs2  = id_use_rs2 & (id_rs2 != '0) & ex_prod & ex_load_q & (ex_q.rd == id_rs2);
    load_use = id_valid & (hit_rs1 | hit_rs2);
  end

  // Freeze forces a hold; a flush kills the consumer so it cannot stall.
  assign stall = freeze | (load_use & ~flush);

  // Shadow pipeline advance and select generation
  always_comb begin
    ex_d      = ex_q;
    ex_load_d = ex_load_q;
    mem_d     = mem_q;
    wb_d      = wb_q;
    wbl_d     = wbl_q;
    sel_a_d   = sel_a_q;
    sel_b_d   = sel_b_q;

    if (!freeze) begin
      mem_d     = ex_q;
      wb_d      = mem_q;
      wbl_d     = wb_q;
      ex_d      = '0;
      ex_load_d = 1'b0;
      sel_a_d   = SEL_RF;
      sel_b_d   = SEL_RF;
      if (!flush && !load_use) begin
        ex_d.valid = id_valid;
        ex_d.rd    = id_rd;
        ex_d.wr    = id_wr_en;
        ex_load_d  = id_is_load;
        if (id_valid) begin
          sel_a_d = code_a;
          sel_b_d = code_b;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q      <= '0;
      ex_load_q <= 1'b0;
      mem_q     <= '0;
      wb_q      <= '0;
      wbl_q     <= '0;
      sel_a_q   <= SEL_RF;
      sel_b_q   <= SEL_RF;
    end else begin
      ex_q      <= ex_d;
      ex_load_q <= ex_load_d;
      mem_q     <= mem_d;
      wb_q      <= wb_d;
      wbl_q     <= wbl_d;
      sel_a_q   <= sel_a_d;
      sel_b_q   <= sel_b_d;
    end
  end

  assign sel_a = sel_a_q;
  assign sel_b = sel_b_q;

`ifdef FWD_STATS_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of real load-use bubbles
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && !freeze && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_count = stall_cnt_q;
`else
  assign stall_count = '0;
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Scoreboard bench for fwd_hazard_ctrl: a distance-based reference model predicts stall and selects,
// a negedge monitor pops the expectations and compares them with the DUT.
module tb_fwd_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_use_rs1, id_use_rs2;
  logic        id_wr_en, id_is_load;
  logic        flush, freeze;
  logic [1:0]  sel_a, sel_b;
  logic        stall;
  logic [31:0] stall_count;

  always #5 clk = ~clk;

  fwd_hazard_ctrl #(.REG_W(5)) dut (
    .clk        (clk),
    .reset      (reset),
    .id_valid   (id_valid),
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_use_rs1 (id_use_rs1),
    .id_use_rs2 (id_use_rs2),
    .id_rd      (id_rd),
    .id_wr_en   (id_wr_en),
    .id_is_load (id_is_load),
    .flush      (flush),
    .freeze     (freeze),
    .sel_a      (sel_a),
    .sel_b      (sel_b),
    .stall      (stall),
    .stall_count(stall_count)
  );

  // Model: in-flight instructions ordered by age, index 0 = one instruction ahead of ID
  typedef struct {
    bit       v;
    bit [4:0] rd;
    bit       wr;
    bit       ld;
  } instr_t;

  typedef struct {
    logic [1:0]  a;
    logic [1:0]  b;
    logic [31:0] cnt;
  } sel_exp_t;

  instr_t   flight[$];
  sel_exp_t sel_q[$];
  bit       stall_q[$];

  logic [1:0]  m_sel_a, m_sel_b;
  logic [31:0] m_cnt;
  int          n_vec = 0;
  int          n_bad = 0;

  function automatic bit writes(instr_t e);
    return e.v && e.wr && (e.rd != 5'd0);
  endfunction

  // Code = how many stages ahead the youngest writer of src is (1..3), 0 if none within reach
  function automatic logic [1:0] model_code(bit used, bit [4:0] src);
    if (!used || src == 5'd0) return 2'd0;
    for (int d = 0; d < 3 && d < flight.size(); d++) begin
      if (writes(flight[d]) && flight[d].rd == src) return 2'(d + 1);
    end
    return 2'd0;
  endfunction

  function automatic bit model_lu(bit v, bit u1, bit [4:0] r1, bit u2, bit [4:0] r2);
    bit hit;
    if (!v || flight.size() == 0) return 1'b0;
    if (!writes(flight[0]) || !flight[0].ld) return 1'b0;
    hit = (u1 && r1 != 5'd0 && r1 == flight[0].rd) || (u2 && r2 != 5'd0 && r2 == flight[0].rd);
    return hit;
  endfunction

  task automatic model_clear();
    instr_t bub;
    bub = '{v: 1'b0, rd: 5'd0, wr: 1'b0, ld: 1'b0};
    flight.delete();
    for (int i = 0; i < 3; i++) flight.push_back(bub);
    m_sel_a = 2'd0;
    m_sel_b = 2'd0;
    m_cnt   = 32'd0;
  endtask

  // One clock cycle: drive, predict, advance model, then queue the post-edge expectation
  task automatic step(input bit rst, input bit fr, input bit fl, input bit v,
                      input bit u1, input bit [4:0] r1, input bit u2, input bit [4:0] r2,
                      input bit [4:0] rd, input bit wr, input bit ld, output bit st);
    bit     lu;
    instr_t ins;
    reset = rst; freeze = fr; flush = fl; id_valid = v;
    id_use_rs1 = u1; id_rs1 = r1; id_use_rs2 = u2; id_rs2 = r2;
    id_rd = rd; id_wr_en = wr; id_is_load = ld;

    lu = model_lu(v, u1, r1, u2, r2);
    st = fr ? 1'b1 : (fl ? 1'b0 : lu);
    stall_q.push_back(st);

    if (rst) begin
      model_clear();
    end else if (!fr) begin
      if (fl || lu) begin
        ins = '{v: 1'b0, rd: 5'd0, wr: 1'b0, ld: 1'b0};
        m_sel_a = 2'd0;
        m_sel_b = 2'd0;
      end else begin
        ins = '{v: v, rd: rd, wr: wr, ld: ld};
        m_sel_a = v ? model_code(u1, r1) : 2'd0;
        m_sel_b = v ? model_code(u2, r2) : 2'd0;
      end
`ifdef FWD_STATS_EN
      if (st && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
`endif
      flight.push_front(ins);
      while (flight.size() > 3) void'(flight.pop_back());
    end

    @(posedge clk);
    #1;
    sel_q.push_back('{a: m_sel_a, b: m_sel_b, cnt: m_cnt});
  endtask

  task automatic ins(input bit u1, input bit [4:0] r1, input bit u2, input bit [4:0] r2,
                     input bit [4:0] rd, input bit wr, input bit ld,
                     input bit fl = 1'b0, input bit fr = 1'b0, input bit rst = 1'b0);
    bit st;
    step(rst, fr, fl, 1'b1, u1, r1, u2, r2, rd, wr, ld, st);
  endtask

  task automatic nop();
    bit st;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, st);
  endtask

  always @(negedge clk) begin
    bit       es;
    sel_exp_t ex;
    if (stall_q.size() > 0) begin
      es = stall_q.pop_front();
      n_vec++;
      if (stall !== es) begin
        n_bad++;
        $display("FAIL stall at %0t: got %0b expected %0b", $time, stall, es);
      end
    end
    if (sel_q.size() > 0) begin
      ex = sel_q.pop_front();
      n_vec += 3;
      if (sel_a !== ex.a) begin
        n_bad++;
        $display("FAIL sel_a at %0t: got %0b expected %0b", $time, sel_a, ex.a);
      end
      if (sel_b !== ex.b) begin
        n_bad++;
        $display("FAIL sel_b at %0t: got %0b expected %0b", $time, sel_b, ex.b);
      end
      if (stall_count !== ex.cnt) begin
        n_bad++;
        $display("FAIL stall_count at %0t: got %0d expected %0d", $time, stall_count, ex.cnt);
      end
    end
  end

  initial begin
    bit       st, hold;
    bit       rv, ru1, ru2, rwr, rld, rfl, rfr, rrst;
    bit [4:0] rr1, rr2, rrd;

    reset = 1'b1; freeze = 1'b0; flush = 1'b0; id_valid = 1'b0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; id_rs1 = '0; id_rs2 = '0;
    id_rd = '0; id_wr_en = 1'b0; id_is_load = 1'b0;
    model_clear();
    @(posedge clk);
    #1;

    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, st);
    nop();

    // Back-to-back ALU forward
    ins(0, 0, 0, 0, 5, 1, 0);
    ins(1, 5, 1, 6, 1, 1, 0);
    nop();
    // Distance 2, 3, 4 on rs2
    ins(0, 0, 0, 0, 7, 1, 0); nop(); ins(0, 0, 1, 7, 2, 1, 0);
    ins(0, 0, 0, 0, 7, 1, 0); nop(); nop(); ins(0, 0, 1, 7, 2, 1, 0);
    ins(0, 0, 0, 0, 7, 1, 0); nop(); nop(); nop(); ins(0, 0, 1, 7, 2, 1, 0);
    // Load-use: one bubble then WB forward
    ins(0, 0, 0, 0, 3, 1, 1);
    ins(1, 3, 0, 0, 4, 1, 0);
    ins(1, 3, 0, 0, 4, 1, 0);
    nop();
    // x0 load never stalls or forwards
    ins(0, 0, 0, 0, 0, 1, 1);
    ins(1, 0, 1, 0, 1, 1, 0);
    // Youngest wins
    ins(0, 0, 0, 0, 9, 1, 0); ins(0, 0, 0, 0, 9, 1, 0); ins(1, 9, 1, 9, 1, 1, 0);
    nop(); nop(); nop();
    // Flush with load-use hazard
    ins(0, 0, 0, 0, 4, 1, 1);
    ins(1, 4, 1, 4, 5, 1, 0, 1'b1);
    nop();
    // Freeze during pending forward
    ins(0, 0, 0, 0, 6, 1, 0);
    ins(1, 6, 0, 0, 1, 1, 0, 1'b0, 1'b1);
    ins(1, 6, 0, 0, 1, 1, 0, 1'b0, 1'b1);
    ins(1, 6, 0, 0, 1, 1, 0, 1'b0, 1'b1);
    ins(1, 6, 0, 0, 1, 1, 0);
    // Reset mid-stall
    ins(0, 0, 0, 0, 8, 1, 1);
    ins(0, 0, 1, 8, 1, 1, 0);
    ins(0, 0, 1, 8, 1, 1, 0, 1'b0, 1'b0, 1'b1);
    ins(0, 0, 1, 8, 1, 1, 0);
    nop();

    // Randomized traffic on a small register window; ID holds while stalled
    hold = 1'b0;
    rv = 0; ru1 = 0; ru2 = 0; rr1 = 0; rr2 = 0; rrd = 0; rwr = 0; rld = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!hold) begin
        rv  = ($urandom_range(0, 9) != 0);
        ru1 = $urandom_range(0, 1) != 0;
        ru2 = $urandom_range(0, 1) != 0;
        rr1 = 5'($urandom_range(0, 7));
        rr2 = 5'($urandom_range(0, 7));
        rrd = 5'($urandom_range(0, 7));
        rwr = ($urandom_range(0, 4) != 0);
        rld = ($urandom_range(0, 2) == 0);
      end
      rfl  = ($urandom_range(0, 11) == 0);
      rfr  = ($urandom_range(0, 9) == 0);
      rrst = ($urandom_range(0, 149) == 0);
      step(rrst, rfr, rfl, rv, ru1, rr1, ru2, rr2, rrd, rwr, rld, st);
      hold = st && !rrst && !rfl;
    end

    nop();
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
